ascon_rc_seq_ti: RTL and testbench
==================================

# ascon_rc_seq_ti

Parametrised, sequenced round-constant stage for the threshold-implemented Ascon permutation. Operates on the x2 lane split into SHARES Boolean shares. Per accepted round it optionally re-masks the shares with fresh randomness and XORs the round constant into the last share. It tracks the round index itself for any round count 1..12, registers its output behind a valid/ready handshake, and sits between the masked substitution layer and the linear layer in the round datapath.

## Interface
- SHARES, 3: number of shares (>= 2).
- WIDTH, 64: lane width in bits (>= 8).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse; begins a permutation run; sampled only in IDLE.
- rounds  in  4  round count for the run, legal 1..12; latched on start.
- in_valid  in  1  round input available.
- in_ready  out  1  block accepts round input this cycle.
- x2_in  in  SHARES*WIDTH  input shares; share j is bits [j*WIDTH +: WIDTH].
- rnd_in  in  (SHARES-1)*WIDTH  fresh randomness r_0..r_{SHARES-2}.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream accepts output.
- x2_out  out  SHARES*WIDTH  output shares.
- round_idx  out  4  index i (0-based) of the round held in x2_out.
- last  out  1  x2_out holds the final round of the run.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last output is accepted.
- err  out  1  one-cycle pulse when start carries an illegal rounds value.

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE, start=1, rounds in 1..12: latch rounds to R and clear ctr to 0. Next state RUN.
- IDLE, start=1, rounds 0 or 13..15: err=1 for the next cycle. Stay IDLE.
- start outside IDLE is ignored.
- RUN: in_ready = !out_valid || out_ready.
- On accept (in_valid && in_ready), register the output:
  - share j < SHARES-1: x2_in_j ^ r_j.
  - last share: x2_in_last ^ (XOR of all r_j) ^ C.
  - C is zero-extended to WIDTH and occupies bits [7:0].
- Constant rules:
  - k = 12 - R + ctr, held in 4 bits.
  - C = {4'(15-k), 4'(k)}, equivalent to 0xF0 - 15*k.
  - Run with R=12 spans 0xF0..0x4B; any run ends at 0x4B.
- On each accept: round_idx <= ctr, last <= (ctr == R-1), ctr increments.
- Accepting the round with ctr == R-1 moves the FSM to FLUSH.
- FLUSH: in_ready=0. When out_valid && out_ready:
  - out_valid clears, done pulses on the next cycle, next state IDLE.
- Output regs hold their value while out_valid && !out_ready.
- Output accept and new input accept in the same cycle are legal in RUN and give full throughput.
- Share XOR of x2_out equals XOR of x2_in ^ C, independent of rnd_in.

## Timing
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 round/cycle when out_ready stays high.
- Reset values: in_ready=0, out_valid=0, x2_out=0, round_idx=0, last=0, busy=0, done=0, err=0. FSM enters IDLE with ctr=0 and R=0.
- busy rises the cycle after a legal start and falls in the cycle done pulses.
- start is accepted one cycle after done (back-to-back runs allowed).
- rst in any state aborts the run on that edge and drops in-flight output.

## Configuration
- ASCON_RC_REMASK_EN defined: re-masking with rnd_in as described above.
- ASCON_RC_REMASK_EN undefined:
  - rnd_in is ignored (unused port kept).
  - Share j < SHARES-1 passes x2_in_j unchanged.
  - Last share = x2_in_last ^ C.
  - Timing and FSM are identical.

## Test plan
- rounds=12, shares 0, r=0, out_ready=1, 12 back-to-back inputs -> 12 outputs, last-share constants F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B. last=1 only with round_idx=11. done pulses once.
- rounds=6 and rounds=8 -> first constants 0x96 and 0xB4, both ending 0x4B. rounds=1 -> single output 0x4B with last=1.
- rounds=0 and rounds=13 -> err pulse, busy stays 0, no outputs.
- Random shares and rnd with ASCON_RC_REMASK_EN defined -> XOR of output shares equals XOR of input shares ^ C on every round. Shares differ from the undefined-macro build.
- out_ready toggled pseudo-randomly -> x2_out stable while stalled, no round lost or duplicated, in_ready=0 throughout FLUSH.
- rst asserted mid-run at round_idx=5 -> next cycle all outputs at reset values. A following start with rounds=12 restarts at 0xF0.

Source files
------------

// File: rtl/ascon_rc_seq_ti.sv
// ascon_rc_seq_ti: sequenced round-constant stage for the threshold-implemented
// Ascon permutation, operating on the x2 lane split into SHARES Boolean shares.
// Optional feature macro: ASCON_RC_REMASK_EN (re-masks shares with rnd_in).
module ascon_rc_seq_ti #(
    parameter int unsigned SHARES = 3,
    parameter int unsigned WIDTH  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [3:0]                    rounds,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SHARES*WIDTH-1:0]       x2_in,
    input  logic [(SHARES-1)*WIDTH-1:0]   rnd_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SHARES*WIDTH-1:0]       x2_out,
    output logic [3:0]                    round_idx,
    output logic                          last,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned XW = SHARES * WIDTH;
    localparam int unsigned RW = (SHARES - 1) * WIDTH;

`ifdef ASCON_RC_REMASK_EN
    localparam bit REMASK = 1'b1;
`else
    localparam bit REMASK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      r_q, r_d;
    logic [3:0]      ctr_q, ctr_d;
    logic            ov_q, ov_d;
    logic [XW-1:0]   x2_q, x2_d;
    logic [3:0]      idx_q, idx_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [RW-1:0]   rnd_eff;
    logic [XW-1:0]   x2_new;
    logic [WIDTH-1:0] rnd_acc;
    logic [3:0]      k;
    logic [7:0]      rc;
    logic            rounds_ok;
    logic            accept;
    logic            out_fire;
    logic            final_round;

    // Without re-masking the randomness is gated to zero; the port stays for drop-in use.
    assign rnd_eff = REMASK ? rnd_in : '0;

    assign rounds_ok   = (rounds != 4'd0) && (rounds <= 4'd12);
    assign k           = 4'(4'd12 - r_q + ctr_q);
    assign rc          = {4'(4'd15 - k), k};
    assign in_ready    = (state_q == RUN) && (!ov_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign out_fire    = ov_q && out_ready;
    assign final_round = (ctr_q == 4'(r_q - 4'd1));

    assign out_valid = ov_q;
    assign x2_out    = x2_q;
    assign round_idx = idx_q;
    assign last      = last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

    // Round datapath: re-mask leading shares, fold all masks and the constant into the last share.
    always_comb begin
        x2_new  = '0;
        rnd_acc = '0;
        for (int unsigned j = 0; j < SHARES - 1; j++) begin
            x2_new[j*WIDTH +: WIDTH] = x2_in[j*WIDTH +: WIDTH] ^ rnd_eff[j*WIDTH +: WIDTH];
            rnd_acc                  = rnd_acc ^ rnd_eff[j*WIDTH +: WIDTH];
        end
        x2_new[(SHARES-1)*WIDTH +: WIDTH] = x2_in[(SHARES-1)*WIDTH +: WIDTH] ^ rnd_acc ^ WIDTH'(rc);
    end

    // Next-state and output-register update for the IDLE/RUN/FLUSH sequencer.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        ctr_d   = ctr_q;
        ov_d    = ov_q;
        x2_d    = x2_q;
        idx_d   = idx_q;
        last_d  = last_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (rounds_ok) begin
                        r_d     = rounds;
                        ctr_d   = '0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_fire) begin
                    ov_d = 1'b0;
                end
                if (accept) begin
                    ov_d   = 1'b1;
                    x2_d   = x2_new;
                    idx_d  = ctr_q;
                    last_d = final_round;
                    ctr_d  = 4'(ctr_q + 4'd1);
                    if (final_round) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_fire) begin
                    ov_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            ctr_q   <= '0;
            ov_q    <= 1'b0;
            x2_q    <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            ctr_q   <= ctr_d;
            ov_q    <= ov_d;
            x2_q    <= x2_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ascon_rc_seq_ti.sv
// Self-checking bench for ascon_rc_seq_ti using a scoreboard of expected rounds.
module tb_ascon_rc_seq_ti;

    localparam int S  = 3;
    localparam int W  = 64;
    localparam int XW = S * W;
    localparam int RW = (S - 1) * W;

`ifdef ASCON_RC_REMASK_EN
    localparam bit REM = 1'b1;
`else
    localparam bit REM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]    rounds, round_idx;
    logic [XW-1:0] x2_in, x2_out;
    logic [RW-1:0] rnd_in;
    logic          last, busy, done, err;

    always #5 clk = ~clk;

    ascon_rc_seq_ti #(.SHARES(S), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .rounds(rounds),
        .in_valid(in_valid), .in_ready(in_ready), .x2_in(x2_in), .rnd_in(rnd_in),
        .out_valid(out_valid), .out_ready(out_ready), .x2_out(x2_out),
        .round_idx(round_idx), .last(last), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [XW-1:0] x2;
        logic [W-1:0]  xs;
        logic [3:0]    idx;
        logic          lst;
    } exp_t;

    exp_t       sbq[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         m_R = 0;
    int         push_base = 0, out_base = 0;
    int         push_cnt = 0, out_cnt = 0, done_cnt = 0;
    logic [7:0] cs [16];
    logic       stall_prev = 1'b0;
    logic [XW-1:0] x2_prev = '0;

    // Monitor/scoreboard: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic [W-1:0] racc, rj, sh, ox;
        logic [7:0]   c;
        int           n, k;
        if (rst) begin
            sbq.delete();
            stall_prev = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stall_prev) begin
                vectors++;
                if (out_valid !== 1'b1 || x2_out !== x2_prev) begin
                    miscompares++;
                    $display("FAIL stall_hold: valid=%b x2_out=%h required valid=1 x2_out=%h", out_valid, x2_out, x2_prev);
                end
            end
            if (out_valid && last) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL flush_in_ready: got %b required 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_underflow: unexpected output idx=%0d", round_idx);
                end else begin
                    e  = sbq.pop_front();
                    ox = '0;
                    for (int j = 0; j < S; j++) ox = ox ^ x2_out[j*W +: W];
                    if (x2_out !== e.x2 || ox !== e.xs || round_idx !== e.idx || last !== e.lst) begin
                        miscompares++;
                        $display("FAIL round_out: x2=%h idx=%0d last=%b xor=%h required x2=%h idx=%0d last=%b xor=%h",
                                 x2_out, round_idx, last, ox, e.x2, e.idx, e.lst, e.xs);
                    end
                    n = out_cnt - out_base;
                    if (n >= 0 && n < 16) cs[n] = x2_out[(S-1)*W +: 8];
                end
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                n    = push_cnt - push_base;
                k    = 12 - m_R + n;
                c    = 8'(240 - 15 * k);
                racc = '0;
                e.xs = '0;
                e.x2 = '0;
                for (int j = 0; j < S - 1; j++) begin
                    sh = x2_in[j*W +: W];
                    rj = REM ? rnd_in[j*W +: W] : '0;
                    e.x2[j*W +: W] = sh ^ rj;
                    racc = racc ^ rj;
                    e.xs = e.xs ^ sh;
                end
                sh = x2_in[(S-1)*W +: W];
                e.x2[(S-1)*W +: W] = sh ^ racc ^ {56'b0, c};
                e.xs  = e.xs ^ sh ^ {56'b0, c};
                e.idx = 4'(n);
                e.lst = (n == m_R - 1);
                sbq.push_back(e);
                push_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            x2_prev    = x2_out;
        end
    end

    task automatic new_data(input bit zero);
        for (int i = 0; i < XW / 32; i++) x2_in[i*32 +: 32] = zero ? 32'h0 : $urandom;
        for (int i = 0; i < RW / 32; i++) rnd_in[i*32 +: 32] = zero ? 32'h0 : $urandom;
    endtask

    // Runs one permutation; abort_idx >= 0 returns early once that round is on the output.
    task automatic drive_run(input logic [3:0] r, input bit rnd_rdy, input bit zero, input int abort_idx);
        int db, seen;
        bit fin;
        @(posedge clk); #1;
        m_R       = int'(r);
        push_base = push_cnt;
        out_base  = out_cnt;
        db        = done_cnt;
        for (int i = 0; i < 16; i++) cs[i] = 8'h00;
        start  = 1'b1;
        rounds = r;
        @(posedge clk); #1;
        start = 1'b0;
        new_data(zero);
        in_valid = 1'b1;
        seen = push_cnt;
        fin  = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (push_cnt != seen) begin
                seen = push_cnt;
                new_data(zero);
            end
            if (push_cnt - push_base >= m_R) in_valid = 1'b0;
            if (done_cnt != db) fin = 1'b1;
            if (abort_idx >= 0 && out_valid && int'(round_idx) == abort_idx) return;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL run_timeout: rounds=%0d no done within budget", r);
        end
        vectors++;
        if (out_cnt - out_base != m_R || sbq.size() != 0) begin
            miscompares++;
            $display("FAIL round_count: got %0d outputs (%0d pending) required %0d", out_cnt - out_base, sbq.size(), m_R);
        end
        @(posedge clk); #1;
        vectors++;
        if (done_cnt - db != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done count %0d busy=%b required 1 and 0", done_cnt - db, busy);
        end
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || x2_out !== '0 || round_idx !== 4'd0 ||
            last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: rdy=%b ov=%b x2=%h idx=%0d last=%b busy=%b done=%b err=%b required all zero",
                     tag, in_ready, out_valid, x2_out, round_idx, last, busy, done, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rounds = 4'd0; in_valid = 1'b0; out_ready = 1'b1;
        x2_in = '0; rnd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_r12_constants();
        logic [7:0] tbl [12];
        tbl = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
        drive_run(4'd12, 1'b0, 1'b1, -1);
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (cs[i] !== tbl[i]) begin
                miscompares++;
                $display("FAIL r12_const[%0d]: got %h required %h", i, cs[i], tbl[i]);
            end
        end
    endtask

    task automatic test_short_runs();
        drive_run(4'd6, 1'b0, 1'b1, -1);
        vectors++;
        if (cs[0] !== 8'h96 || cs[5] !== 8'h4B) begin
            miscompares++;
            $display("FAIL r6_const: first %h last %h required 96 4b", cs[0], cs[5]);
        end
        drive_run(4'd8, 1'b0, 1'b1, -1);
        vectors++;
        if (cs[0] !== 8'hB4 || cs[7] !== 8'h4B) begin
            miscompares++;
            $display("FAIL r8_const: first %h last %h required b4 4b", cs[0], cs[7]);
        end
        drive_run(4'd1, 1'b0, 1'b1, -1);
        vectors++;
        if (cs[0] !== 8'h4B) begin
            miscompares++;
            $display("FAIL r1_const: got %h required 4b", cs[0]);
        end
    endtask

    task automatic test_illegal_rounds();
        logic [3:0] bad [2];
        int oc;
        bad = '{4'd0, 4'd13};
        for (int i = 0; i < 2; i++) begin
            oc = out_cnt;
            @(posedge clk); #1;
            start = 1'b1; rounds = bad[i];
            @(posedge clk); #1;
            start = 1'b0;
            vectors++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL err_pulse: rounds=%0d err=%b busy=%b required 1 0", bad[i], err, busy);
            end
            @(posedge clk); #1;
            vectors++;
            if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_cnt != oc) begin
                miscompares++;
                $display("FAIL err_after: rounds=%0d err=%b busy=%b ov=%b required 0 0 0", bad[i], err, busy, out_valid);
            end
        end
    endtask

    task automatic test_random_masks();
        drive_run(4'd12, 1'b0, 1'b0, -1);
        drive_run(4'd3, 1'b0, 1'b0, -1);
    endtask

    task automatic test_stall();
        drive_run(4'd12, 1'b1, 1'b0, -1);
        drive_run(4'd5, 1'b1, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        drive_run(4'd2, 1'b0, 1'b0, -1);
        drive_run(4'd4, 1'b0, 1'b0, -1);
    endtask

    task automatic test_rst_midrun();
        drive_run(4'd12, 1'b0, 1'b0, 5);
        vectors++;
        if (round_idx !== 4'd5 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_point: idx=%0d ov=%b required 5 1", round_idx, out_valid);
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("midrun_reset");
        out_ready = 1'b1;
        drive_run(4'd12, 1'b0, 1'b1, -1);
        vectors++;
        if (cs[0] !== 8'hF0 || cs[11] !== 8'h4B) begin
            miscompares++;
            $display("FAIL restart_const: first %h last %h required f0 4b", cs[0], cs[11]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_r12_constants();
        test_short_runs();
        test_illegal_rounds();
        test_random_masks();
        test_stall();
        test_back_to_back();
        test_rst_midrun();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
